phy_led_drive: RTL and testbench

- Transmit-side counterpart of the port LED receive path: generates the two PHY-style LED pins from internal link and traffic status.
  - led1 is the activity LED, active-high, blinks on traffic.
  - led2_n is the link LED, active-low.
- Downstream, the LED input conditioning (inverting link filter, blink AND) consumes exactly this encoding.
- Instantiated once per port, between the MAC status logic and the LED pads or loopback test harness.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_sig_debounce.sv | 42 ++++
 rtl/phy_led_drive.sv | 122 ++++++++++++
 tb/tb_phy_led_drive.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the port LED drive/receive paths.
// Latency: n/a (package only); no backpressure.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } act_state_e;

  // Defaults assume a 50 MHz core clock: 50 ms blink phases, 10 ms link debounce.
  localparam int unsigned DEF_BLINK_ON_CYC  = 2500000;
  localparam int unsigned DEF_BLINK_OFF_CYC = 2500000;
  localparam int unsigned DEF_LINK_DEB_CYC  = 500000;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_sig_debounce.sv
// Stable-for-N filter: dout follows din once din has differed from dout for N consecutive cycles.
// Latency: N cycles from a stable change to dout; no backpressure.
module led_sig_debounce
  import led_pkg::*;
#(
  parameter int unsigned N = DEF_LINK_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         dout_q, dout_d;

  // Counter holds how many cycles din has already disagreed; any agreement restarts it.
  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == LAST) dout_d = din;
      else               cnt_d  = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/phy_led_drive.sv
// PHY-style LED pin generator: debounced active-low link LED and blink-per-traffic activity LED.
// Latency: blink starts 1 cycle after an event, link LED follows LINK_DEB_CYC cycles after a stable change; no backpressure.
module phy_led_drive
  import led_pkg::*;
#(
  parameter int unsigned BLINK_ON_CYC  = DEF_BLINK_ON_CYC,
  parameter int unsigned BLINK_OFF_CYC = DEF_BLINK_OFF_CYC,
  parameter int unsigned LINK_DEB_CYC  = DEF_LINK_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic c_done,
  input  logic link_up,
  input  logic rx_ok,
  input  logic tx_ok,
  output logic led1,
  output logic led2_n,
  output logic link_shown,
  output logic blink_busy
);

  localparam int unsigned CW = cnt_width(max2(BLINK_ON_CYC, BLINK_OFF_CYC));
  localparam logic [CW-1:0] ON_LOAD  = CW'(BLINK_ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(BLINK_OFF_CYC - 1);

  act_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          led1_q, led1_d;
  logic          busy_q, busy_d;
  logic          c_done_q;
  logic          link_shown_q;
  logic          ev;

  led_sig_debounce #(.N(LINK_DEB_CYC)) u_link_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (link_up),
    .dout  (link_shown_q)
  );

  assign ev = (rx_ok | tx_ok) & link_shown_q & c_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      led1_q   <= 1'b0;
      busy_q   <= 1'b0;
      c_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      led1_q   <= led1_d;
      busy_q   <= busy_d;
      c_done_q <= c_done;
    end
  end

  // An event on the last OFF cycle counts as pending, so blinks chain back-to-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (!c_done || !link_shown_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev) begin
            state_d = ST_ON;
            cnt_d   = ON_LOAD;
          end
        end
        ST_ON: begin
          if (ev) pend_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_OFF;
            cnt_d   = OFF_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_OFF: begin
          if (cnt_q == '0) begin
            if (pend_q || ev) begin
              state_d = ST_ON;
              cnt_d   = ON_LOAD;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (ev) pend_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    led1_d = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  assign led1       = led1_q;
  assign blink_busy = busy_q;
  assign link_shown = link_shown_q;
  // Both terms are flops, so the pin has no path from any input.
  assign led2_n     = ~(link_shown_q & c_done_q);

endmodule

// File: tb/tb_phy_led_drive.sv
// Directed bench for phy_led_drive with a cycle-indexed reference model checked every cycle.
module tb_phy_led_drive;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int DEB = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic c_done = 1'b1;
  logic link_up = 1'b0;
  logic rx_ok = 1'b0;
  logic tx_ok = 1'b0;
  logic led1, led2_n, link_shown, blink_busy;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  phy_led_drive #(
    .BLINK_ON_CYC  (ON),
    .BLINK_OFF_CYC (OFF),
    .LINK_DEB_CYC  (DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .c_done     (c_done),
    .link_up    (link_up),
    .rx_ok      (rx_ok),
    .tx_ok      (tx_ok),
    .led1       (led1),
    .led2_n     (led2_n),
    .link_shown (link_shown),
    .blink_busy (blink_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: blink phase is derived from the index of the cycle the blink began.
  int cyc = 0;
  int m_run = 0;
  int m_start = 0;
  bit m_shown = 0, m_cdq = 0, m_act = 0, m_pend = 0;
  bit e_led1 = 0, e_busy = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc = 0; m_run = 0; m_start = 0;
      m_shown = 0; m_cdq = 0; m_act = 0; m_pend = 0;
      e_led1 = 0; e_busy = 0;
    end else begin : step
      bit ev;
      ev = (rx_ok || tx_ok) && m_shown && c_done;
      if (!m_shown || !c_done) begin
        m_act = 0; m_pend = 0;
      end else if (!m_act) begin
        if (ev) begin m_act = 1; m_start = cyc + 1; end
      end else if (cyc - m_start == ON + OFF - 1) begin
        if (m_pend || ev) begin m_start = cyc + 1; m_pend = 0; end
        else m_act = 0;
      end else if (ev) begin
        m_pend = 1;
      end
      if (link_up != m_shown) begin
        m_run++;
        if (m_run == DEB) begin m_shown = !m_shown; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_cdq = c_done;
      cyc++;
      e_led1 = m_act && (cyc - m_start < ON);
      e_busy = m_act;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("model_led1", led1, e_led1);
      chk("model_busy", blink_busy, e_busy);
      chk("model_link_shown", link_shown, m_shown);
      chk("model_led2_n", led2_n, !(m_shown && m_cdq));
    end
  end

  initial begin
    logic [16:0] rx3, tx3, led3, busy3;
    logic [12:0] rx4;
    logic [15:0] rx5;
    rx3 = 17'h00041; tx3 = 17'h00064; led3 = 17'h00F1E; busy3 = 17'h07FFE;
    rx4 = 13'h0504;
    rx5 = 16'h0454;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_led1", led1, 1'b0);
    chk("reset_led2_n", led2_n, 1'b1);
    chk("reset_link_shown", link_shown, 1'b0);
    chk("reset_busy", blink_busy, 1'b0);
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Short link glitch is ignored, a held rise shows after DEB cycles.
    link_up = 1'b1; tick(4);
    link_up = 1'b0; tick(3);
    chk("glitch_led2_n", led2_n, 1'b1);
    link_up = 1'b1; tick(4);
    chk("deb_not_yet", link_shown, 1'b0);
    tick(1);
    chk("deb_shown", link_shown, 1'b1);
    chk("deb_led2_n", led2_n, 1'b0);

    // Single blink.
    rx_ok = 1'b1; tick(1); rx_ok = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("single_led1", led1, (k <= ON));
      chk("single_busy", blink_busy, (k <= ON + OFF));
      tick(1);
    end

    // Collapsed pending events give exactly one follow-on blink.
    for (int i = 0; i <= 16; i++) begin
      rx_ok = rx3[i]; tx_ok = tx3[i];
      chk("pend_led1", led1, led3[i]);
      chk("pend_busy", blink_busy, busy3[i]);
      tick(1);
    end
    rx_ok = 1'b0; tx_ok = 1'b0;

    // Link drop truncates a running blink and blocks new ones.
    for (int i = 0; i <= 12; i++) begin
      link_up = 1'b0; rx_ok = rx4[i];
      if (i == 4) chk("drop_still_shown", link_shown, 1'b1);
      if (i == 5) begin
        chk("drop_shown", link_shown, 1'b0);
        chk("drop_led2_n", led2_n, 1'b1);
        chk("drop_led1_last", led1, 1'b1);
      end
      if (i == 6) begin
        chk("drop_led1", led1, 1'b0);
        chk("drop_busy", blink_busy, 1'b0);
      end
      if (i > 6) chk("drop_no_blink", led1, 1'b0);
      tick(1);
    end
    rx_ok = 1'b0;
    link_up = 1'b1; tick(8);

    // c_done low blanks both LEDs; release restores link LED next cycle.
    for (int i = 0; i <= 15; i++) begin
      c_done = (i >= 8); rx_ok = rx5[i];
      if (i >= 1 && i <= 8) chk("cdone_led2_n_off", led2_n, 1'b1);
      if (i == 9) chk("cdone_led2_n_on", led2_n, 1'b0);
      chk("cdone_led1", led1, (i >= 11 && i <= 14));
      tick(1);
    end
    rx_ok = 1'b0;
    tick(4);

    // Async reset mid-ON with a pending blink.
    rx_ok = 1'b1; tick(1); rx_ok = 1'b0; tick(1);
    rx_ok = 1'b1; tick(1); rx_ok = 1'b0;
    chk("rst_pre_led1", led1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_led1", led1, 1'b0);
    chk("rst_async_led2_n", led2_n, 1'b1);
    chk("rst_async_shown", link_shown, 1'b0);
    chk("rst_async_busy", blink_busy, 1'b0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("rst_no_blink_led1", led1, 1'b0);
      chk("rst_no_blink_busy", blink_busy, 1'b0);
      tick(1);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
